rv32_mem_stage: RTL and testbench
=================================

RV32_MEM_STAGE -- requirements
Module: rv32_mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, is the maximum number of cycles spent in WAIT without dmem_ack before a bus error.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  exec stage presents an instruction.
REQ-005 ex_ready  output  1  stage accepts; equals (state==IDLE) and !rst.
REQ-006 ex_alu_result  input  rv32_word  ALU result: the address for memory ops, the result otherwise.
REQ-007 ex_store_data  input  rv32_word  rs2 value for stores.
REQ-008 ex_mem_op  input  mem_op_t  MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH or SW.
REQ-009 ex_rd  input  5; ex_wb_en  input  1  destination register and its write enable.
REQ-010 dmem_req  output  1; dmem_we  output  1; dmem_addr  output  rv32_word, with bits [1:0] forced to 0; dmem_be  output  4; dmem_wdata  output  rv32_word.
REQ-011 dmem_ack  input  1; dmem_rdata  input  rv32_word  response in the ack cycle.
REQ-012 wb_valid  output  1; wb_rd  output  5; wb_en  output  1; wb_data  output  rv32_word; wb_misalign  output  1; wb_bus_err  output  1.

Function
REQ-013 An instruction is accepted on a clock edge where ex_valid and ex_ready are both high; fields are captured in internal registers.
REQ-014 MEM_NONE: wb_valid pulses for one cycle, the cycle after acceptance, with wb_data=ex_alu_result and wb_en=ex_wb_en; the state stays IDLE.
REQ-015 Misaligned access:
- LH, LHU or SH with addr[0]=1;
- LW or SW with addr[1:0]!=0.
A misaligned access issues no bus request and produces a one-cycle wb_valid the next cycle with wb_misalign=1, wb_en=0 and wb_data=address.
REQ-016 An aligned load or store moves IDLE->WAIT.
- dmem_req is high from the cycle after acceptance until the cycle in which dmem_ack is sampled high.
- addr, we, be and wdata are held stable while dmem_req is high.
REQ-017 In WAIT, dmem_ack high -> IDLE.
- wb_valid pulses the next cycle.
- Loads: wb_en=ex_wb_en, data extracted from dmem_rdata as captured in the ack cycle.
- Stores: wb_en=0.
REQ-018 Store lanes:
- SB: byte replicated on all four lanes, be=1<<addr[1:0].
- SH: halfword replicated, be=0011 if addr[1]=0, else 1100.
- SW: be=1111.
REQ-019 Load extraction: LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW passes the full word through.
REQ-020 A wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
- On reaching ACK_TIMEOUT: dmem_req drops, state returns to IDLE, wb_valid pulses with wb_bus_err=1 and wb_en=0.
- An ack in the same cycle as the timeout takes priority over the timeout.
REQ-021 Latency:
- MEM_NONE and misaligned accesses: 1 cycle.
- Memory ops: 1 + (cycles until ack) + 1.
- Back-to-back MEM_NONE sustains one instruction per cycle.
REQ-022 wb_misalign and wb_bus_err are 0 whenever wb_valid is 0; when wb_valid is 0, wb_data holds its last value.

Reset
REQ-023 While rst is high:
- state=IDLE, counter=0;
- dmem_req, dmem_we, dmem_be, wb_valid, wb_en, wb_misalign, wb_bus_err = 0;
- dmem_addr, dmem_wdata, wb_data, wb_rd = 0;
- ex_ready=0.
REQ-024 Reset asserted in WAIT drops dmem_req asynchronously and discards the in-flight access; no wb_valid follows for it.

Structure
REQ-025 mem_op_t and the MEM_* encodings are defined in the shared rv32_types package; rv32_word comes from the same package.
REQ-026 Load extraction and store lane steering form one combinational sub-module, rv32_mem_align, instantiated once.

Verification
REQ-027 MEM_NONE, result 0x0000_1234, rd=5, wb_en=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x0000_1234, dmem_req never high.
REQ-028 SB to addr 0x103 with data 0xAB, ack after 3 cycles:
- dmem_addr=0x100, be=1000, wdata=0xABABABAB, we=1;
- wb_valid one cycle after ack with wb_en=0.
REQ-029 LB from 0x102 with rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; LBU from the same address and rdata -> wb_data=0x0000_0080.
REQ-030 LW from 0x106 -> no dmem_req; next cycle wb_misalign=1, wb_en=0, wb_data=0x106.
REQ-031 LW, ack never arrives, ACK_TIMEOUT=4 -> dmem_req drops after 4 WAIT cycles, wb_bus_err=1; a following MEM_NONE is accepted the next cycle.
REQ-032 rst asserted in the 2nd WAIT cycle of an SW -> dmem_req low immediately; after release, no wb_valid and ex_ready=1.

Source files
------------

// File: rtl/rv32_types_pkg.sv
// Shared RV32 types: data word, memory op encodings and MEM-stage state.
// Small predicates on mem_op_t used by both the stage and its aligner.
package rv32_types;

    typedef logic [31:0] rv32_word;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_mem(input mem_op_t op);
        return op != MEM_NONE;
    endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// Store lane steering, misalignment detection and load extraction.
// Purely combinational; store side sees the EX op, load side the held op.
module rv32_mem_align
    import rv32_types::*;
(
    input  mem_op_t    st_op,
    input  logic [1:0] st_off,
    input  rv32_word   st_data,
    output logic [3:0] st_be,
    output rv32_word   st_wdata,
    output logic       st_misalign,
    input  mem_op_t    ld_op,
    input  logic [1:0] ld_off,
    input  rv32_word   ld_rdata,
    output rv32_word   ld_data
);

    rv32_word    shifted;
    logic [15:0] half;

    always_comb begin
        st_be       = 4'b0000;
        st_wdata    = st_data;
        st_misalign = 1'b0;
        unique case (st_op)
            MEM_SB: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            MEM_SH: begin
                st_be       = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata    = {2{st_data[15:0]}};
                st_misalign = st_off[0];
            end
            MEM_SW: begin
                st_be       = 4'b1111;
                st_misalign = st_off != 2'b00;
            end
            MEM_LH, MEM_LHU: st_misalign = st_off[0];
            MEM_LW:          st_misalign = st_off != 2'b00;
            default: ;
        endcase
    end

    assign shifted = ld_rdata >> {ld_off, 3'b000};
    assign half    = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        ld_data = ld_rdata;
        unique case (ld_op)
            MEM_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: ld_data = {24'h0, shifted[7:0]};
            MEM_LH:  ld_data = {{16{half[15]}}, half};
            MEM_LHU: ld_data = {16'h0, half};
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_mem_stage.sv
// RV32 memory stage: one outstanding data-bus access with ack timeout.
// Non-memory and misaligned instructions retire the cycle after acceptance.
module rv32_mem_stage
    import rv32_types::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    output logic       ex_ready,
    input  rv32_word   ex_alu_result,
    input  rv32_word   ex_store_data,
    input  mem_op_t    ex_mem_op,
    input  logic [4:0] ex_rd,
    input  logic       ex_wb_en,
    output logic       dmem_req,
    output logic       dmem_we,
    output rv32_word   dmem_addr,
    output logic [3:0] dmem_be,
    output rv32_word   dmem_wdata,
    input  logic       dmem_ack,
    input  rv32_word   dmem_rdata,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_en,
    output rv32_word   wb_data,
    output logic       wb_misalign,
    output logic       wb_bus_err
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_op_t       op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic          wben_q, wben_d;
    logic [1:0]    off_q, off_d;

    logic       req_d, we_d;
    rv32_word   addr_d, wdata_d;
    logic [3:0] be_d;
    logic       wbv_d, wben_o_d, mis_d, berr_d;
    logic [4:0] wbrd_d;
    rv32_word   wbdata_d;

    logic       accept, timeout, mis, go_wait;
    logic [3:0] st_be;
    rv32_word   st_wdata, ld_data;

    assign ex_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;
    assign timeout  = cnt_q == TMO_LAST;
    assign go_wait  = accept && is_mem(ex_mem_op) && !mis;

    rv32_mem_align u_align (
        .st_op       (ex_mem_op),
        .st_off      (ex_alu_result[1:0]),
        .st_data     (ex_store_data),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .st_misalign (mis),
        .ld_op       (op_q),
        .ld_off      (off_q),
        .ld_rdata    (dmem_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (go_wait) state_d = ST_WAIT;
            ST_WAIT: if (dmem_ack || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        wben_d   = wben_q;
        off_d    = off_q;
        req_d    = dmem_req;
        we_d     = dmem_we;
        addr_d   = dmem_addr;
        be_d     = dmem_be;
        wdata_d  = dmem_wdata;
        wbv_d    = 1'b0;
        wben_o_d = 1'b0;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        wbrd_d   = wb_rd;
        wbdata_d = wb_data;
        if (accept) begin
            op_d   = ex_mem_op;
            rd_d   = ex_rd;
            wben_d = ex_wb_en;
            off_d  = ex_alu_result[1:0];
            if (!is_mem(ex_mem_op)) begin
                wbv_d    = 1'b1;
                wben_o_d = ex_wb_en;
                wbrd_d   = ex_rd;
                wbdata_d = ex_alu_result;
            end else if (mis) begin
                wbv_d    = 1'b1;
                mis_d    = 1'b1;
                wbrd_d   = ex_rd;
                wbdata_d = ex_alu_result;
            end else begin
                cnt_d   = '0;
                req_d   = 1'b1;
                we_d    = is_store(ex_mem_op);
                addr_d  = {ex_alu_result[31:2], 2'b00};
                be_d    = st_be;
                wdata_d = st_wdata;
            end
        end
        if (state_q == ST_WAIT) begin
            // An ack wins over a timeout landing in the same cycle.
            if (dmem_ack) begin
                req_d    = 1'b0;
                wbv_d    = 1'b1;
                wbrd_d   = rd_q;
                wben_o_d = !is_store(op_q) && wben_q;
                if (!is_store(op_q)) wbdata_d = ld_data;
            end else if (timeout) begin
                req_d  = 1'b0;
                wbv_d  = 1'b1;
                berr_d = 1'b1;
                wbrd_d = rd_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            op_q        <= MEM_NONE;
            rd_q        <= '0;
            wben_q      <= 1'b0;
            off_q       <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_en       <= 1'b0;
            wb_misalign <= 1'b0;
            wb_bus_err  <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            wben_q      <= wben_d;
            off_q       <= off_d;
            dmem_req    <= req_d;
            dmem_we     <= we_d;
            dmem_addr   <= addr_d;
            dmem_be     <= be_d;
            dmem_wdata  <= wdata_d;
            wb_valid    <= wbv_d;
            wb_en       <= wben_o_d;
            wb_misalign <= mis_d;
            wb_bus_err  <= berr_d;
            wb_rd       <= wbrd_d;
            wb_data     <= wbdata_d;
        end
    end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Directed bench for rv32_mem_stage with ACK_TIMEOUT=4.
// Expected values are hand-computed constants.
module tb_rv32_mem_stage;
    import rv32_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic       ex_ready;
    rv32_word   ex_alu_result;
    rv32_word   ex_store_data;
    mem_op_t    ex_mem_op;
    logic [4:0] ex_rd;
    logic       ex_wb_en;
    logic       dmem_req;
    logic       dmem_we;
    rv32_word   dmem_addr;
    logic [3:0] dmem_be;
    rv32_word   dmem_wdata;
    logic       dmem_ack;
    rv32_word   dmem_rdata;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_en;
    rv32_word   wb_data;
    logic       wb_misalign;
    logic       wb_bus_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv32_mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_op     (ex_mem_op),
        .ex_rd         (ex_rd),
        .ex_wb_en      (ex_wb_en),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_en         (wb_en),
        .wb_data       (wb_data),
        .wb_misalign   (wb_misalign),
        .wb_bus_err    (wb_bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mem_op_t op, input rv32_word a,
                         input rv32_word d, input logic [4:0] rd,
                         input logic we);
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_alu_result = a;
        ex_store_data = d;
        ex_rd         = rd;
        ex_wb_en      = we;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_mem_op = MEM_NONE;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_mem_op = MEM_NONE;
        ex_rd = '0;
        ex_wb_en = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        #3;
        check("rst_ready", ex_ready, 0);
        check("rst_req", dmem_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_addr", dmem_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", ex_ready, 1);

        // MEM_NONE
        drive(MEM_NONE, 32'h0000_1234, 0, 5'd5, 1'b1);
        tick();
        idle();
        check("none_wbv", wb_valid, 1);
        check("none_rd", wb_rd, 5);
        check("none_data", wb_data, 32'h0000_1234);
        check("none_en", wb_en, 1);
        check("none_req", dmem_req, 0);
        tick();
        check("none_wbv_drop", wb_valid, 0);
        check("none_hold", wb_data, 32'h0000_1234);
        check("none_req2", dmem_req, 0);

        // back-to-back MEM_NONE
        drive(MEM_NONE, 32'hA, 0, 5'd1, 1'b1);
        tick();
        check("b2b_v1", wb_valid, 1);
        check("b2b_d1", wb_data, 32'hA);
        check("b2b_rdy", ex_ready, 1);
        drive(MEM_NONE, 32'hB, 0, 5'd2, 1'b1);
        tick();
        idle();
        check("b2b_v2", wb_valid, 1);
        check("b2b_d2", wb_data, 32'hB);
        check("b2b_rd2", wb_rd, 2);

        // SB 0x103, ack in third request cycle
        drive(MEM_SB, 32'h103, 32'hAB, 5'd0, 1'b0);
        tick();
        idle();
        check("sb_req", dmem_req, 1);
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_be", dmem_be, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_we", dmem_we, 1);
        check("sb_ready", ex_ready, 0);
        check("sb_wbv0", wb_valid, 0);
        tick();
        check("sb_req2", dmem_req, 1);
        tick();
        check("sb_req3", dmem_req, 1);
        check("sb_addr3", dmem_addr, 32'h100);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("sb_wbv", wb_valid, 1);
        check("sb_wben", wb_en, 0);
        check("sb_req_drop", dmem_req, 0);
        check("sb_ready2", ex_ready, 1);

        // SH 0x102 and SW 0x200 lane steering
        drive(MEM_SH, 32'h102, 32'h1234_CDEF, 5'd0, 1'b0);
        tick();
        idle();
        check("sh_be", dmem_be, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'hCDEF_CDEF);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("sh_wbv", wb_valid, 1);
        drive(MEM_SW, 32'h200, 32'hDEAD_BEEF, 5'd0, 1'b0);
        tick();
        idle();
        check("sw_be", dmem_be, 4'b1111);
        check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check("sw_addr", dmem_addr, 32'h200);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;

        // LB / LBU from 0x102
        drive(MEM_LB, 32'h102, 0, 5'd7, 1'b1);
        tick();
        idle();
        check("lb_req", dmem_req, 1);
        check("lb_we", dmem_we, 0);
        check("lb_addr", dmem_addr, 32'h100);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0080_0000;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        check("lb_wbv", wb_valid, 1);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_en", wb_en, 1);
        check("lb_rd", wb_rd, 7);
        drive(MEM_LBU, 32'h102, 0, 5'd7, 1'b1);
        tick();
        idle();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0080_0000;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        check("lbu_data", wb_data, 32'h0000_0080);

        // LH / LHU upper half
        drive(MEM_LH, 32'h102, 0, 5'd8, 1'b1);
        tick();
        idle();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h8001_0000;
        tick();
        dmem_ack = 1'b0;
        check("lh_data", wb_data, 32'hFFFF_8001);
        drive(MEM_LHU, 32'h102, 0, 5'd8, 1'b1);
        tick();
        idle();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        check("lhu_data", wb_data, 32'h0000_8001);

        // misaligned LW 0x106
        drive(MEM_LW, 32'h106, 0, 5'd9, 1'b1);
        tick();
        idle();
        check("mis_req", dmem_req, 0);
        check("mis_wbv", wb_valid, 1);
        check("mis_flag", wb_misalign, 1);
        check("mis_en", wb_en, 0);
        check("mis_data", wb_data, 32'h106);
        tick();
        check("mis_wbv_drop", wb_valid, 0);
        check("mis_flag_drop", wb_misalign, 0);
        check("mis_req2", dmem_req, 0);
        drive(MEM_SH, 32'h101, 32'h55, 5'd0, 1'b0);
        tick();
        idle();
        check("mis_sh_flag", wb_misalign, 1);
        check("mis_sh_req", dmem_req, 0);

        // timeout: no ack for 4 WAIT cycles
        drive(MEM_LW, 32'h300, 0, 5'd3, 1'b1);
        tick();
        idle();
        check("to_req1", dmem_req, 1);
        tick();
        tick();
        tick();
        check("to_req4", dmem_req, 1);
        check("to_wbv4", wb_valid, 0);
        tick();
        check("to_req_drop", dmem_req, 0);
        check("to_wbv", wb_valid, 1);
        check("to_berr", wb_bus_err, 1);
        check("to_en", wb_en, 0);
        check("to_ready", ex_ready, 1);
        drive(MEM_NONE, 32'h77, 0, 5'd4, 1'b1);
        tick();
        idle();
        check("to_next_wbv", wb_valid, 1);
        check("to_next_berr", wb_bus_err, 0);
        check("to_next_data", wb_data, 32'h77);

        // ack in the timeout cycle wins
        drive(MEM_LW, 32'h304, 0, 5'd6, 1'b1);
        tick();
        idle();
        tick();
        tick();
        tick();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234_5678;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        check("race_wbv", wb_valid, 1);
        check("race_berr", wb_bus_err, 0);
        check("race_data", wb_data, 32'h1234_5678);
        check("race_en", wb_en, 1);

        // reset during 2nd WAIT cycle of an SW
        drive(MEM_SW, 32'h400, 32'h1111_2222, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        check("rw_req_pre", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("rw_req_async", dmem_req, 0);
        check("rw_ready", ex_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rw_ready2", ex_ready, 1);
        tick();
        check("rw_wbv1", wb_valid, 0);
        tick();
        check("rw_wbv2", wb_valid, 0);
        check("rw_req", dmem_req, 0);
        check("rw_ready3", ex_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
